// File: rtl/comparador_autenticacao_seq.sv
// Sequential access-code comparator with per-level stored codes, grant hold,
// single-cycle deny pulse and lockout after too many consecutive failures.
module comparador_autenticacao_seq #(
    parameter int CODE_W      = 6,
    parameter int N_LEVELS    = 3,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int HOLD_CYCLES = 4,
    localparam int LVL_W      = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1,
    localparam int TRY_W      = $clog2(MAX_TRIES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CODE_W-1:0]   code_in,
    input  logic                code_valid,
    input  logic                prog_en,
    input  logic [LVL_W-1:0]    prog_level,
    input  logic [CODE_W-1:0]   prog_code,
    output logic                ready,
    output logic [N_LEVELS-1:0] aut,
    output logic                denied,
    output logic                locked,
    output logic [TRY_W-1:0]    tries_left
);

    // The timer is shared by GRANT and LOCKED, so it must hold the larger count.
    localparam int TMAX  = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
    localparam int TIM_W = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        GRANT  = 3'd2,
        DENY   = 3'd3,
        LOCKED = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CODE_W-1:0]   codes_q [N_LEVELS];
    logic [CODE_W-1:0]   codes_d [N_LEVELS];
    logic [TRY_W-1:0]    fail_q, fail_d;
    logic [TIM_W-1:0]    timer_q, timer_d;
    logic [N_LEVELS-1:0] aut_q, aut_d;
    logic [N_LEVELS-1:0] grant_oh;
    logic                any_hit;
    logic                hold_done;
    logic                lock_done;
    logic                last_try;

    // Parallel compare of the captured code; later (higher) levels overwrite lower hits.
    always_comb begin
        grant_oh = '0;
        any_hit  = 1'b0;
        for (int i = 0; i < N_LEVELS; i++) begin
            if (codes_q[i] == code_q) begin
                grant_oh = '0;
                grant_oh[i] = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

    // Terminal-count and last-attempt flags shared by next-state and datapath logic.
    always_comb begin
        hold_done = (int'(timer_q) >= HOLD_CYCLES - 1);
        lock_done = (int'(timer_q) >= LOCK_CYCLES - 1);
        last_try  = (int'(fail_q) + 1 >= MAX_TRIES);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!prog_en && code_valid) state_d = CHECK;
            CHECK:   state_d = any_hit ? GRANT : (last_try ? LOCKED : DENY);
            GRANT:   if (hold_done) state_d = IDLE;
            DENY:    state_d = IDLE;
            LOCKED:  if (lock_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: code capture, programming, failure count and timer.
    always_comb begin
        code_d  = code_q;
        codes_d = codes_q;
        fail_d  = fail_q;
        timer_d = timer_q;
        aut_d   = aut_q;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (prog_en) begin
                    for (int i = 0; i < N_LEVELS; i++) begin
                        if (int'(prog_level) == i) codes_d[i] = prog_code;
                    end
                end else if (code_valid) begin
                    code_d = code_in;
                end
            end
            CHECK: begin
                timer_d = '0;
                if (any_hit) begin
                    aut_d  = grant_oh;
                    fail_d = '0;
                end else if (last_try) begin
                    fail_d = TRY_W'(MAX_TRIES);
                end else begin
                    fail_d = fail_q + 1'b1;
                end
            end
            GRANT: begin
                timer_d = hold_done ? '0 : timer_q + 1'b1;
            end
            LOCKED: begin
                if (lock_done) begin
                    timer_d = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: timer_d = '0;
        endcase
    end

    // Datapath registers; stored codes reset to level index plus one.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            fail_q  <= '0;
            timer_q <= '0;
            aut_q   <= '0;
            for (int i = 0; i < N_LEVELS; i++) begin
                codes_q[i] <= CODE_W'(i + 1);
            end
        end else begin
            code_q  <= code_d;
            fail_q  <= fail_d;
            timer_q <= timer_d;
            aut_q   <= aut_d;
            codes_q <= codes_d;
        end
    end

    // Outputs decoded purely from registered state and counters.
    always_comb begin
        ready      = (state_q == IDLE);
        aut        = (state_q == GRANT) ? aut_q : '0;
        denied     = (state_q == DENY);
        locked     = (state_q == LOCKED);
        tries_left = TRY_W'(MAX_TRIES) - fail_q;
    end

endmodule

// File: doc/comparador_autenticacao_seq.md
COMPARADOR_AUTENTICACAO_SEQ -- requirements
Module: comparador_autenticacao_seq

Interface
REQ-001 Parameter CODE_W, default 6: width in bits of an access code.
REQ-002 Parameter N_LEVELS, default 3: number of access levels, each with one stored code.
REQ-003 Parameter MAX_TRIES, default 3: consecutive failed attempts that trigger lockout (>=1).
REQ-004 Parameter LOCK_CYCLES, default 16: lockout duration in clock cycles (>=1).
REQ-005 Parameter HOLD_CYCLES, default 4: cycles a grant is held (>=1).
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock; all state updates on the rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 code_in  input  CODE_W  code presented for authentication.
REQ-010 code_valid  input  1  code_in is valid this cycle.
REQ-011 prog_en  input  1  write prog_code into the stored code of level prog_level.
REQ-012 prog_level  input  $clog2(N_LEVELS)  level index to program.
REQ-013 prog_code  input  CODE_W  new code value.
REQ-014 ready  output  1  high only in IDLE; the block accepts code_valid/prog_en.
REQ-015 aut  output  N_LEVELS  one-hot granted level; all-zero when no grant.
REQ-016 denied  output  1  one-cycle pulse on failed attempt without lockout.
REQ-017 locked  output  1  high for the whole lockout.
REQ-018 tries_left  output  $clog2(MAX_TRIES+1)  MAX_TRIES minus current failure count.

Function
REQ-019 FSM states: IDLE, CHECK, GRANT, DENY, LOCKED; all outputs are decoded from registered state/counters only.
REQ-020 IDLE with code_valid=1 and prog_en=0: capture code_in into a register and go to CHECK next edge.
REQ-021 IDLE with prog_en=1: write prog_code to level prog_level and stay in IDLE; code_valid the same cycle is ignored.
REQ-022 prog_level >= N_LEVELS: write ignored.
REQ-023 code_valid and prog_en outside IDLE: ignored, no side effects.
REQ-024 CHECK (exactly one cycle): compare captured code against all N_LEVELS stored codes in parallel.
REQ-025 Several levels match: highest index wins; aut one-hot at that index.
REQ-026 Match: go to GRANT, clear failure count.
REQ-027 No match and failure count+1 < MAX_TRIES: increment count, go to DENY.
REQ-028 No match and failure count+1 = MAX_TRIES: go to LOCKED, tries_left reads 0.
REQ-029 GRANT: aut held for exactly HOLD_CYCLES cycles, then IDLE.
REQ-030 DENY: denied=1 for exactly one cycle, then IDLE.
REQ-031 LOCKED: locked=1 for exactly LOCK_CYCLES cycles, then IDLE with failure count cleared to 0.
REQ-032 Latency: code_valid sampled at edge k, CHECK during k..k+1, GRANT/DENY/LOCKED outputs visible after edge k+2.
REQ-033 Back-to-back: next code is accepted on the first cycle ready=1 after returning to IDLE.
REQ-034 Counters saturate: no wrap-around for any parameter value.

Reset
REQ-035 rst=1 at an edge, from any state including mid-GRANT or mid-LOCKED: state IDLE, failure count 0, all counters 0.
REQ-036 After reset: ready=1, aut=0, denied=0, locked=0, tries_left=MAX_TRIES.
REQ-037 Stored code of level i resets to i+1 (zero-extended to CODE_W), so defaults are 1, 2, 3.
REQ-038 rst has priority over prog_en and code_valid in the same cycle.

Verification
REQ-039 Reset, code_in=6'd2 with code_valid -> after 2 edges aut=3'b010 for 4 cycles, then ready=1, tries_left=3.
REQ-040 Three wrong codes (6'd9) -> denied pulses after the 1st and 2nd (tries_left 2, 1); 3rd -> locked=1 for 16 cycles, tries_left=0, then IDLE with tries_left=3.
REQ-041 During lockout, code_valid with code 6'd1 -> ignored; locked stays high, aut stays 0.
REQ-042 prog_en, prog_level=0, prog_code=6'd3 (same as level 2) -> code 6'd3 grants aut=3'b100 (priority); code 6'd1 now denied.
REQ-043 prog_en and code_valid together in IDLE -> programming done, no CHECK; ready stays 1.
REQ-044 rst asserted in the 2nd GRANT cycle -> next cycle aut=0, ready=1, stored codes back to 1, 2, 3.
